// File: rtl/bt_cmd_frame_ctrl.sv
// Framed Bluetooth command controller: parses A5/CMD/ARG/CHK frames from the UART
// byte stream and drives song, pause, volume and effect registers with a post-command lockout.
module bt_cmd_frame_ctrl #(
   parameter int SONG_NUM       = 4,
   parameter int SONG_W         = 3,
   parameter int VOL_MAX        = 8,
   parameter int VOL_STEP       = 14,
   parameter int HOLD_CYCLES    = 50000000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   input  logic              i_finish_song,
   output logic [SONG_W-1:0] o_song_select,
   output logic              o_pause,
   output logic              o_next,
   output logic              o_pre,
   output logic              o_auto_next,
   output logic [3:0]        vol_level,
   output logic [15:0]       o_vol,
   output logic [15:0]       o_effect,
   output logic              o_err,
   output logic              o_busy
);
   localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [7:0]        HDR       = 8'hA5;
   localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(SONG_NUM - 1);
   localparam logic [3:0]        VOL_TOP   = 4'(VOL_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_CMD, S_GET_ARG, S_GET_CHK, S_EXEC, S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        cmd_q, cmd_d, arg_q, arg_d, chk_q, chk_d;
   logic              auto_q, auto_d, pend_q, pend_d;
   logic [SONG_W-1:0] song_q, song_d, song_inc, song_dec;
   logic              pause_q, pause_d, next_q, next_d, pre_q, pre_d;
   logic              auto_next_q, auto_next_d, err_q, err_d, busy_q, busy_d;
   logic [3:0]        vol_q, vol_d;
   logic [15:0]       vol_out_q, vol_out_d, effect_q, effect_d;
   logic [7:0]        att;

   assign song_inc = (song_q == SONG_LAST) ? '0 : song_q + 1'b1;
   assign song_dec = (song_q == '0) ? SONG_LAST : song_q - 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      chk_d       = chk_q;
      auto_d      = auto_q;
      pend_d      = pend_q | i_finish_song;
      song_d      = song_q;
      pause_d     = pause_q;
      vol_d       = vol_q;
      effect_d    = effect_q;
      next_d      = 1'b0;
      pre_d       = 1'b0;
      auto_next_d = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // A fresh header wins over a pending auto-advance; the advance runs after the frame.
            if (i_rx_valid && i_rx_data == HDR) begin
               state_d = S_GET_CMD;
               auto_d  = 1'b0;
            end else if (pend_q) begin
               state_d = S_EXEC;
               auto_d  = 1'b1;
            end
         end
         S_GET_CMD, S_GET_ARG, S_GET_CHK: begin
            if (i_rx_valid) begin
               cnt_d = '0;
               case (state_q)
                  S_GET_CMD: begin cmd_d = i_rx_data; state_d = S_GET_ARG; end
                  S_GET_ARG: begin arg_d = i_rx_data; state_d = S_GET_CHK; end
                  default:   begin chk_d = i_rx_data; state_d = S_EXEC;    end
               endcase
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            auto_d  = 1'b0;
            if (auto_q) begin
               // Finish indications arriving in this cycle are absorbed by this advance.
               song_d      = song_inc;
               auto_next_d = 1'b1;
               pend_d      = 1'b0;
               state_d     = S_HOLD;
            end else if (chk_q != (cmd_q ^ arg_q)) begin
               err_d = 1'b1;
            end else begin
               case (cmd_q)
                  8'h01: pause_d = ~pause_q;
                  8'h02: begin song_d = song_inc; next_d = 1'b1; state_d = S_HOLD; end
                  8'h03: begin song_d = song_dec; pre_d  = 1'b1; state_d = S_HOLD; end
                  8'h04: begin
                     if (vol_q != '0) vol_d = vol_q - 1'b1;
                     state_d = S_HOLD;
                  end
                  8'h05: begin
                     if (vol_q < VOL_TOP) vol_d = vol_q + 1'b1;
                     state_d = S_HOLD;
                  end
                  8'h06: begin
                     if (arg_q < 8'(SONG_NUM)) begin
                        song_d  = SONG_W'(arg_q);
                        next_d  = 1'b1;
                        state_d = S_HOLD;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  8'h07: begin
                     vol_d   = (arg_q > 8'(VOL_MAX)) ? VOL_TOP : arg_q[3:0];
                     state_d = S_HOLD;
                  end
                  8'h08: begin
                     case (arg_q)
                        8'h00:   effect_d = 16'h0000;
                        8'h01:   effect_d = 16'h0707;
                        8'h02:   effect_d = 16'hF0F0;
                        default: err_d    = 1'b1;
                     endcase
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      att       = (vol_d == VOL_TOP) ? 8'hFC : 8'(vol_d * VOL_STEP);
      vol_out_d = {att, att};
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         arg_q       <= '0;
         chk_q       <= '0;
         auto_q      <= 1'b0;
         pend_q      <= 1'b0;
         song_q      <= '0;
         pause_q     <= 1'b1;
         vol_q       <= '0;
         vol_out_q   <= '0;
         effect_q    <= '0;
         next_q      <= 1'b0;
         pre_q       <= 1'b0;
         auto_next_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         arg_q       <= arg_d;
         chk_q       <= chk_d;
         auto_q      <= auto_d;
         pend_q      <= pend_d;
         song_q      <= song_d;
         pause_q     <= pause_d;
         vol_q       <= vol_d;
         vol_out_q   <= vol_out_d;
         effect_q    <= effect_d;
         next_q      <= next_d;
         pre_q       <= pre_d;
         auto_next_q <= auto_next_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign o_song_select = song_q;
   assign o_pause       = pause_q;
   assign o_next        = next_q;
   assign o_pre         = pre_q;
   assign o_auto_next   = auto_next_q;
   assign vol_level     = vol_q;
   assign o_vol         = vol_out_q;
   assign o_effect      = effect_q;
   assign o_err         = err_q;
   assign o_busy        = busy_q;
endmodule

// File: tb/tb_bt_cmd_frame_ctrl.sv
// Bench for bt_cmd_frame_ctrl: directed frame table, multi-cycle corner sequences,
// and random frames checked against a frame-level reference model.
module tb_bt_cmd_frame_ctrl;
   localparam int N = 4, SW = 3, VM = 8, VS = 14, HC = 20, TC = 40;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          i_rx_valid = 1'b0, i_finish_song = 1'b0;
   logic [7:0]    i_rx_data = 8'h00;
   logic [SW-1:0] o_song_select;
   logic          o_pause, o_next, o_pre, o_auto_next, o_err, o_busy;
   logic [3:0]    vol_level;
   logic [15:0]   o_vol, o_effect;

   always #5 clk = ~clk;

   bt_cmd_frame_ctrl #(.SONG_NUM(N), .SONG_W(SW), .VOL_MAX(VM), .VOL_STEP(VS),
                       .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .rst_n(rst_n), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
      .i_finish_song(i_finish_song), .o_song_select(o_song_select), .o_pause(o_pause),
      .o_next(o_next), .o_pre(o_pre), .o_auto_next(o_auto_next), .vol_level(vol_level),
      .o_vol(o_vol), .o_effect(o_effect), .o_err(o_err), .o_busy(o_busy));

   typedef struct {
      logic [7:0]  cmd, arg, chk;
      int          gap;
      bit          fin, hold;
      int          song;
      bit          pause;
      int          vol;
      logic [15:0] eff;
      int          nxt, pre, aut, err;
   } vec_t;

   int n_vec = 0, n_err = 0;
   int c_next = 0, c_pre = 0, c_auto = 0, c_errp = 0, c_busy = 0;
   int m_song = 0, m_vol = 0;
   bit m_pause = 1'b1;
   logic [15:0] m_eff = 16'h0000;
   vec_t tbl[$];

   // Pulse/busy cycle counters, sampled on the falling edge.
   always @(negedge clk) if (rst_n) begin
      c_next <= c_next + int'(o_next);
      c_pre  <= c_pre + int'(o_pre);
      c_auto <= c_auto + int'(o_auto_next);
      c_errp <= c_errp + int'(o_err);
      c_busy <= c_busy + int'(o_busy);
   end

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] att_of(input int v);
      logic [7:0] a;
      a = (v == VM) ? 8'hFC : 8'(v * VS);
      return {a, a};
   endfunction

   function automatic vec_t mk(input logic [7:0] c, a, k, input int g, input bit f, h,
                               input int s, input bit p, input int vl, input logic [15:0] e,
                               input int nx, pr, au, er);
      vec_t v;
      v.cmd = c; v.arg = a; v.chk = k; v.gap = g; v.fin = f; v.hold = h;
      v.song = s; v.pause = p; v.vol = vl; v.eff = e;
      v.nxt = nx; v.pre = pr; v.aut = au; v.err = er;
      return v;
   endfunction

   // Frame-level reference: effect of one complete frame on the player state.
   function automatic vec_t model_frame(input logic [7:0] c, a, k, input int g, input bit f);
      vec_t v;
      v = mk(c, a, k, g, f, 1'b0, m_song, m_pause, m_vol, m_eff, 0, 0, 0, 0);
      if (k != (c ^ a)) v.err = 1;
      else case (c)
         8'h01: v.pause = !m_pause;
         8'h02: begin v.song = (m_song + 1) % N; v.nxt = 1; v.hold = 1; end
         8'h03: begin v.song = (m_song + N - 1) % N; v.pre = 1; v.hold = 1; end
         8'h04: begin v.vol = (m_vol > 0) ? m_vol - 1 : 0; v.hold = 1; end
         8'h05: begin v.vol = (m_vol < VM) ? m_vol + 1 : VM; v.hold = 1; end
         8'h06: if (a < N) begin v.song = a; v.nxt = 1; v.hold = 1; end else v.err = 1;
         8'h07: begin v.vol = (a > VM) ? VM : int'(a); v.hold = 1; end
         8'h08: if (a == 0) v.eff = 16'h0000;
                else if (a == 1) v.eff = 16'h0707;
                else if (a == 2) v.eff = 16'hF0F0;
                else v.err = 1;
         default: v.err = 1;
      endcase
      if (f) begin v.song = (v.song + 1) % N; v.aut = 1; end
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit fin);
      i_rx_valid = 1'b1; i_rx_data = b; i_finish_song = fin;
      @(posedge clk); #1;
      i_rx_valid = 1'b0; i_finish_song = 1'b0; i_rx_data = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_quiet();
      int lows = 0;
      for (int k = 0; k < 400 && lows < 3; k++) begin
         @(negedge clk);
         lows = o_busy ? 0 : lows + 1;
      end
      #1;
      check("settle", int'(lows >= 3), 1);
   endtask

   task automatic check_regs(input string tag);
      check({tag, " song"}, int'(o_song_select), m_song);
      check({tag, " pause"}, int'(o_pause), int'(m_pause));
      check({tag, " vol"}, int'(vol_level), m_vol);
      check({tag, " o_vol"}, int'(o_vol), int'(att_of(m_vol)));
      check({tag, " effect"}, int'(o_effect), int'(m_eff));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int s_n, s_p, s_a, s_e, s_b, eb;
      s_n = c_next; s_p = c_pre; s_a = c_auto; s_e = c_errp; s_b = c_busy;
      send_byte(8'hA5, 1'b0); idle(v.gap);
      send_byte(v.cmd, v.fin); idle(v.gap);
      send_byte(v.arg, 1'b0); idle(v.gap);
      send_byte(v.chk, 1'b0);
      wait_quiet();
      m_song = v.song; m_pause = v.pause; m_vol = v.vol; m_eff = v.eff;
      check_regs(tag);
      check({tag, " next"}, c_next - s_n, v.nxt);
      check({tag, " pre"}, c_pre - s_p, v.pre);
      check({tag, " auto"}, c_auto - s_a, v.aut);
      check({tag, " err"}, c_errp - s_e, v.err);
      eb = 3 * (v.gap + 1) + 1 + (v.hold ? HC + 1 : 0) + (v.fin ? HC + 2 : 0);
      check({tag, " busy"}, c_busy - s_b, eb);
   endtask

   task automatic tie(input bit lead, input string tag);
      int s_a, s_n, pc, ac;
      bit p0;
      p0 = o_pause; s_a = c_auto; s_n = c_next; pc = -1; ac = -1;
      if (lead) begin
         i_finish_song = 1'b1; @(posedge clk); #1; i_finish_song = 1'b0;
         send_byte(8'hA5, 1'b0);
      end else send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (pc < 0 && o_pause != p0) pc = i;
         if (ac < 0 && o_auto_next) ac = i;
      end
      wait_quiet();
      m_pause = !m_pause; m_song = (m_song + 1) % N;
      check_regs(tag);
      check({tag, " pause first"}, int'(pc >= 0 && ac > pc), 1);
      check({tag, " auto"}, c_auto - s_a, 1);
      check({tag, " next"}, c_next - s_n, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int s_n, s_a, s_e, s_b, k;
      logic [7:0] c, a, ck, j;

      // Directed frames from reset: song 0, paused, loudest, no effect.
      tbl.push_back(mk(8'h02, 8'h00, 8'h02, 0, 0, 1, 1, 1, 0, 16'h0000, 1, 0, 0, 0));
      tbl.push_back(mk(8'h03, 8'h00, 8'h03, 1, 0, 1, 0, 1, 0, 16'h0000, 0, 1, 0, 0));
      tbl.push_back(mk(8'h03, 8'h00, 8'h03, 0, 0, 1, 3, 1, 0, 16'h0000, 0, 1, 0, 0));
      tbl.push_back(mk(8'h02, 8'h00, 8'h02, 2, 0, 1, 0, 1, 0, 16'h0000, 1, 0, 0, 0));
      for (int i = 1; i <= 10; i++)
         tbl.push_back(mk(8'h05, 8'h00, 8'h05, 0, 0, 1, 0, 1, (i > 8) ? 8 : i, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h07, 8'h03, 8'h04, 0, 0, 1, 0, 1, 3, 16'h0000, 0, 0, 0, 0));
      for (int i = 2; i >= 0; i--)
         tbl.push_back(mk(8'h04, 8'h00, 8'h04, 0, 0, 1, 0, 1, i, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h04, 8'h00, 8'h04, 0, 0, 1, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h02, 8'h00, 8'h03, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1));
      tbl.push_back(mk(8'h06, 8'h05, 8'h03, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1));
      tbl.push_back(mk(8'h09, 8'h00, 8'h09, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1));
      tbl.push_back(mk(8'h06, 8'h02, 8'h04, 0, 0, 1, 2, 1, 0, 16'h0000, 1, 0, 0, 0));
      tbl.push_back(mk(8'h01, 8'h00, 8'h01, 1, 0, 0, 2, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h08, 8'h01, 8'h09, 0, 0, 0, 2, 0, 0, 16'h0707, 0, 0, 0, 0));
      tbl.push_back(mk(8'h08, 8'h02, 8'h0A, 0, 0, 0, 2, 0, 0, 16'hF0F0, 0, 0, 0, 0));
      tbl.push_back(mk(8'h08, 8'h03, 8'h0B, 0, 0, 0, 2, 0, 0, 16'hF0F0, 0, 0, 0, 1));
      tbl.push_back(mk(8'h08, 8'h00, 8'h08, 0, 0, 0, 2, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h07, 8'h0F, 8'h08, 0, 0, 1, 2, 0, 8, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h07, 8'h00, 8'h07, 0, 0, 1, 2, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(8'h02, 8'h00, 8'h02, 0, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 1, 0));
      tbl.push_back(mk(8'h01, 8'h00, 8'h01, 0, 1, 0, 1, 1, 0, 16'h0000, 0, 0, 1, 0));
      tbl.push_back(mk(8'h06, 8'h03, 8'h05, 0, 0, 1, 3, 1, 0, 16'h0000, 1, 0, 0, 0));
      tbl.push_back(mk(8'h02, 8'h00, 8'h02, 0, 0, 1, 0, 1, 0, 16'h0000, 1, 0, 0, 0));

      // Reset state, during and after reset.
      idle(3);
      check_regs("rst");
      check("rst busy", int'(o_busy), 0);
      check("rst pulses", int'({o_next, o_pre, o_auto_next, o_err}), 0);
      rst_n = 1'b1;
      idle(3);
      check_regs("post rst");
      check("post rst busy", int'(o_busy), 0);

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("t%0d", i));

      // Two-cycle latency from the checksum byte to the register update.
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      check("lat exec song", int'(o_song_select), m_song);
      check("lat exec next", int'(o_next), 0);
      idle(1);
      m_song = (m_song + 1) % N;
      check("lat song", int'(o_song_select), m_song);
      check("lat next", int'(o_next), 1);
      idle(1);
      check("lat next end", int'(o_next), 0);
      wait_quiet();

      // Three finish pulses during HOLD collapse into one advance after HOLD.
      s_n = c_next; s_a = c_auto; s_b = c_busy;
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      idle(3);
      repeat (3) begin
         i_finish_song = 1'b1; @(posedge clk); #1; i_finish_song = 1'b0; idle(3);
      end
      check("hold auto early", c_auto - s_a, 0);
      wait_quiet();
      m_song = (m_song + 2) % N;
      check_regs("fin3");
      check("fin3 next", c_next - s_n, 1);
      check("fin3 auto", c_auto - s_a, 1);
      check("fin3 busy", c_busy - s_b, 4 + HC + 1 + HC + 2);

      tie(1'b0, "tie");
      tie(1'b1, "lead");

      // Random frames against the reference model.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            s_e = c_errp;
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h00;
            send_byte(j, 0); idle(2);
            check("junk no err", c_errp - s_e, 0);
            check("junk idle", int'(o_busy), 0);
         end
         k = $urandom_range(0, 9);
         c = (k < 9) ? 8'(k) : 8'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
         ck = c ^ a;
         if ($urandom_range(0, 7) == 0) ck = ck ^ 8'($urandom_range(1, 255));
         v = model_frame(c, a, ck, $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
         run_vec(v, $sformatf("rnd%0d", i));
      end

      // Inter-byte timeout inside a frame.
      s_e = c_errp; k = -1;
      send_byte(8'hA5, 0); send_byte(8'h02, 0);
      for (int i = 1; i < TC + 20; i++) begin
         @(negedge clk);
         if (o_err) begin k = i; break; end
      end
      check("timeout seen", int'(k >= TC && k <= TC + 3), 1);
      wait_quiet();
      check("timeout err", c_errp - s_e, 1);
      check("timeout idle", int'(o_busy), 0);
      check_regs("timeout");
      v = model_frame(8'h03, 8'h00, 8'h03, TC - 1, 1'b0);
      run_vec(v, "slow frame");

      // Asynchronous reset mid-HOLD with a pending finish.
      s_a = c_auto;
      send_byte(8'hA5, 0); send_byte(8'h05, 1); send_byte(8'h00, 0); send_byte(8'h05, 0);
      idle(5);
      #2 rst_n = 1'b0;
      #1;
      m_song = 0; m_pause = 1'b1; m_vol = 0; m_eff = 16'h0000;
      check_regs("arst");
      check("arst busy", int'(o_busy), 0);
      @(negedge clk); rst_n = 1'b1;
      idle(HC + 10);
      wait_quiet();
      check("arst pend cleared", c_auto - s_a, 0);
      check_regs("arst after");
      v = model_frame(8'h02, 8'h00, 8'h02, 0, 1'b0);
      run_vec(v, "final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bt_cmd_frame_ctrl.md
Name: bt_cmd_frame_ctrl

Overview:
- Parametrised successor to the single-byte Bluetooth command decoder of the MP3 player.
- Takes the byte stream from the UART receiver and parses framed commands: header 0xA5, CMD, ARG, CHK = CMD^ARG.
- Drives playback controls (song select, pause, next/prev pulses), volume attenuation and effect code.
- Adds absolute song/volume set, frame checksum, inter-byte timeout, an error pulse, and a latched end-of-song auto-advance that a busy controller cannot lose.

Parameters:
SONG_NUM, 4, number of songs; o_song_select wraps within 0..SONG_NUM-1
SONG_W, 3, width of o_song_select; must satisfy 2^SONG_W >= SONG_NUM
VOL_MAX, 8, highest attenuation level; vol_level range 0..VOL_MAX
VOL_STEP, 14, attenuation per level, in 0.5 dB units
HOLD_CYCLES, 50000000, lockout after NEXT/PREV/SELECT/volume commands
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a received byte
i_rx_data  in  8  received byte
i_finish_song  in  1  end-of-song indication from the decoder path (level or pulse)
o_song_select  out  SONG_W  current song index
o_pause  out  1  1 = paused
o_next  out  1  one-cycle pulse on user NEXT or SELECT
o_pre  out  1  one-cycle pulse on user PREV
o_auto_next  out  1  one-cycle pulse on end-of-song advance
vol_level  out  4  current level, 0 = loudest
o_vol  out  16  {att,att}; att = 8'hFC if vol_level==VOL_MAX, else vol_level*VOL_STEP (8-bit)
o_effect  out  16  effect register
o_err  out  1  one-cycle pulse on bad checksum, unknown command, out-of-range ARG or timeout
o_busy  out  1  high in every state other than IDLE

Behaviour:
- Reset: all outputs 0 except o_pause=1. o_vol=16'h0000. State IDLE, all counters 0, pending flag 0.
- States: IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, HOLD.
- IDLE:
  - On i_rx_valid with data 0xA5, go to GET_CMD. This has priority over the pending flag.
  - Other bytes are discarded silently.
  - Else, if pend_finish=1, go to EXEC with an internal AUTO command.
- GET_CMD / GET_ARG / GET_CHK:
  - Each i_rx_valid stores the byte and advances to the next state; GET_CHK advances to EXEC.
  - Timeout counter resets on every byte. When it reaches TIMEOUT_CYCLES: o_err pulse, go to IDLE, partial frame discarded.
- EXEC (exactly one cycle):
  - If CHK != CMD^ARG: o_err, go to IDLE, no state change. Otherwise decode CMD:
  - 0x01 PAUSE: toggle o_pause, go to IDLE.
  - 0x02 NEXT: song = (song==SONG_NUM-1) ? 0 : song+1; o_next pulse; go to HOLD.
  - 0x03 PREV: song = (song==0) ? SONG_NUM-1 : song-1; o_pre pulse; go to HOLD.
  - 0x04 VOL_UP: vol_level = max(vol_level-1, 0); go to HOLD.
  - 0x05 VOL_DOWN: vol_level = min(vol_level+1, VOL_MAX); go to HOLD.
  - 0x06 SELECT: if ARG<SONG_NUM, song=ARG, o_next pulse, go to HOLD; else o_err, go to IDLE.
  - 0x07 VOL_SET: vol_level = min(ARG, VOL_MAX); go to HOLD.
  - 0x08 EFFECT: ARG 0 gives 16'h0000, ARG 1 gives 16'h0707, ARG 2 gives 16'hF0F0; go to IDLE. Any other ARG: o_err, o_effect unchanged.
  - Any other CMD: o_err, go to IDLE.
  - AUTO: NEXT-style advance, o_auto_next pulse (o_next not pulsed), clear pend_finish, go to HOLD.
- HOLD:
  - Counter runs 0..HOLD_CYCLES; at HOLD_CYCLES it clears and the state goes to IDLE.
  - Received bytes are dropped with no o_err.
- pend_finish:
  - Set on any cycle with i_finish_song=1 in any state except EXEC-AUTO.
  - Cleared only by AUTO. Multiple finishes while pending collapse into one advance.
- Outputs are registered. Pulses assert the cycle after EXEC and last exactly one cycle.
- Latency: last frame byte to register update is 2 cycles.
- Asynchronous reset mid-frame or mid-HOLD: return to reset values immediately; pend_finish is cleared.

Test Plan:
- Reset, then frame A5 02 00 02 → o_song_select 0→1, o_next single pulse, o_busy high for HOLD_CYCLES+1 cycles (use HOLD_CYCLES=20 in sim).
- song=0, frame A5 03 00 03 → song=3 (wrap), o_pre pulse. With song=3, frame A5 02 00 02 → song=0.
- Volume: A5 05 00 05 sent ×10 → vol_level saturates at 8, o_vol=16'hFCFC. A5 07 03 04 → vol_level=3, o_vol=16'h2A2A. A5 04 00 04 at level 0 stays 0.
- Errors, each → o_err pulse with no register change:
  - A5 02 00 03 (bad checksum)
  - A5 06 05 03 (SELECT out of range)
  - A5 09 00 09 (unknown command)
  - A5 02 followed by silence for TIMEOUT_CYCLES (timeout; state returns to IDLE)
- Pulse i_finish_song during HOLD → after HOLD ends, one o_auto_next pulse and song+1. Three finish pulses during HOLD still give one advance.
- i_finish_song and header 0xA5 in the same IDLE cycle → frame A5 01 00 01 toggles o_pause first, then the auto-advance executes.
